// File: rtl/sync_meter_pkg.sv
// Shared types and widths for the sync timing meter and its classifier.
package sync_meter_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } meter_state_e;

  localparam int unsigned HCNT_W = 16;
  localparam int unsigned LCNT_W = 11;
  localparam int unsigned FCNT_W = 23;
  localparam int unsigned TCNT_W = 23;

  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
  localparam logic [LCNT_W-1:0] LCNT_MAX = '1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

  function automatic logic [FCNT_W-1:0] abs_diff(input logic [FCNT_W-1:0] a,
                                                 input logic [FCNT_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/sync_edge_sync.sv
// 2-FF synchroniser plus falling-edge detector for an active-low sync wire.
// The fall pulse is registered, three clocks after the pin edge.
module sync_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic sync_in_x,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '1;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[1:0], sync_in_x};
      fall <= sr[2] & ~sr[1];
    end
  end

endmodule

// File: rtl/sync_timing_meter.sv
// Measures line period, lines per field and interlace from active-low syncs.
// Define SYNC_TIMING_METER_FIELD_PERIOD_EN to add the field_period output.
module sync_timing_meter
  import sync_meter_pkg::*;
#(
  parameter int unsigned TOLERANCE     = 8,
  parameter int unsigned STABLE_FIELDS = 4,
  parameter int unsigned LINE_SAMPLE   = 32,
  parameter int unsigned HSYNC_TIMEOUT = 6250,
  parameter int unsigned VSYNC_TIMEOUT = 2500000
) (
  input  logic              clk_50mhz_in,
  input  logic              reset,
  input  logic              vsync_in_x,
  input  logic              hsync_in_x,
  output logic [HCNT_W-1:0] line_period,
  output logic [LCNT_W-1:0] field_lines,
  output logic              interlaced,
  output logic              locked,
  output logic              update
`ifdef SYNC_TIMING_METER_FIELD_PERIOD_EN
  ,
  output logic [FCNT_W-1:0] field_period
`endif
);

  localparam int unsigned       FOK_W    = $clog2(STABLE_FIELDS + 1);
  localparam logic [FOK_W-1:0]  FOK_LAST = FOK_W'(STABLE_FIELDS - 1);
  localparam logic [FOK_W-1:0]  FOK_MAX  = FOK_W'(STABLE_FIELDS);
  localparam logic [TCNT_W-1:0] H_LIM    = TCNT_W'(HSYNC_TIMEOUT);
  localparam logic [TCNT_W-1:0] V_LIM    = TCNT_W'(VSYNC_TIMEOUT);
  localparam logic [LCNT_W-1:0] L_SAMPLE = LCNT_W'(LINE_SAMPLE);
  localparam logic [FCNT_W-1:0] P_TOL    = FCNT_W'(TOLERANCE);

  logic              h_edge, v_edge;
  logic [HCNT_W-1:0] hcnt, p_cur, p_prev;
  logic [LCNT_W-1:0] lcnt, l_prev, l_prev2;
  logic [TCNT_W-1:0] htcnt, vtcnt;
  logic [FOK_W-1:0]  fields_ok;
  logic              p_cap, pair_prev, pair_now, f_close, field_ok;
  logic              timeout, eval, clear_hist;
  meter_state_e      state, state_nx;

  sync_edge_sync u_hsync (.clk(clk_50mhz_in), .reset(reset), .sync_in_x(hsync_in_x), .fall(h_edge));
  sync_edge_sync u_vsync (.clk(clk_50mhz_in), .reset(reset), .sync_in_x(vsync_in_x), .fall(v_edge));

  // hcnt restarts at 1: the edge cycle is the first clock of the new line,
  // so the captured value equals the full edge-to-edge period.
  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      hcnt  <= '0;
      lcnt  <= '0;
      htcnt <= '0;
      vtcnt <= '0;
    end else begin
      if (h_edge) hcnt <= HCNT_W'(1);
      else if (hcnt != HCNT_MAX) hcnt <= hcnt + 1'b1;
      if (v_edge) lcnt <= h_edge ? LCNT_W'(1) : '0;
      else if (h_edge && lcnt != LCNT_MAX) lcnt <= lcnt + 1'b1;
      if (h_edge) htcnt <= '0;
      else if (htcnt != H_LIM) htcnt <= htcnt + 1'b1;
      if (v_edge) vtcnt <= '0;
      else if (vtcnt != V_LIM) vtcnt <= vtcnt + 1'b1;
    end
  end

  assign timeout = (htcnt == H_LIM) || (vtcnt == V_LIM);

`ifdef SYNC_TIMING_METER_FIELD_PERIOD_EN
  logic [FCNT_W-1:0] fcnt, f_prev;

  always_ff @(posedge clk_50mhz_in) begin
    if (reset) fcnt <= '0;
    else if (v_edge) fcnt <= FCNT_W'(1);
    else if (fcnt != FCNT_MAX) fcnt <= fcnt + 1'b1;
  end

  assign f_close = abs_diff(fcnt, f_prev) <= FCNT_W'(TOLERANCE * 16);
`else
  assign f_close = 1'b1;
`endif

  assign pair_now = (lcnt == l_prev + 1'b1) || (l_prev == lcnt + 1'b1);
  assign field_ok = p_cap && f_close
                 && (abs_diff(FCNT_W'(p_cur), FCNT_W'(p_prev)) <= P_TOL)
                 && ((lcnt == l_prev) || (lcnt == l_prev2));

  always_ff @(posedge clk_50mhz_in) begin
    if (reset) state <= SEARCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    eval       = 1'b0;
    clear_hist = 1'b0;
    if (timeout) begin
      state_nx   = SEARCH;
      clear_hist = 1'b1;
    end else if (v_edge) begin
      unique case (state)
        SEARCH:  state_nx = MEASURE;
        MEASURE: begin
          eval = 1'b1;
          if (field_ok && fields_ok == FOK_LAST) state_nx = LOCKED;
        end
        LOCKED: begin
          eval = 1'b1;
          if (!field_ok) state_nx = MEASURE;
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz_in) begin
    if (reset || clear_hist) begin
      p_cur     <= '0;
      p_prev    <= '0;
      l_prev    <= '0;
      l_prev2   <= '0;
      p_cap     <= 1'b0;
      pair_prev <= 1'b0;
      fields_ok <= '0;
`ifdef SYNC_TIMING_METER_FIELD_PERIOD_EN
      f_prev    <= '0;
`endif
    end else begin
      // vsync wins over a coincident hsync, so no capture on that cycle
      if (v_edge) p_cap <= 1'b0;
      else if (h_edge && lcnt == L_SAMPLE) begin
        p_cur <= hcnt;
        p_cap <= 1'b1;
      end
      if (v_edge && state == SEARCH) fields_ok <= '0;
      if (eval) begin
        p_prev    <= p_cur;
        l_prev    <= lcnt;
        l_prev2   <= l_prev;
        pair_prev <= pair_now;
        if (!field_ok) fields_ok <= '0;
        else if (fields_ok != FOK_MAX) fields_ok <= fields_ok + 1'b1;
`ifdef SYNC_TIMING_METER_FIELD_PERIOD_EN
        f_prev    <= fcnt;
`endif
      end
    end
  end

  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      line_period  <= '0;
      field_lines  <= '0;
      interlaced   <= 1'b0;
      update       <= 1'b0;
`ifdef SYNC_TIMING_METER_FIELD_PERIOD_EN
      field_period <= '0;
`endif
    end else begin
      update <= eval;
      if (eval) begin
        line_period  <= p_cur;
        field_lines  <= lcnt;
        interlaced   <= pair_now && pair_prev;
`ifdef SYNC_TIMING_METER_FIELD_PERIOD_EN
        field_period <= fcnt;
`endif
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
